// File: rtl/ram_burst_pkg.sv
// Shared defaults and state encoding for the RAM burst controller.
package ram_burst_pkg;

  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ram_burst_rd_stage.sv
// Read output register: valid/data/last with load, hold and clear control.
module ram_burst_rd_stage
  import ram_burst_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_in,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  // Load has priority; a consumed beat with no replacement drops valid but keeps data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      last  <= last_in;
    end else if (clear) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write controller for a small asynchronous-read RAM.
// Optional feature: RAM_BURST_CTRL_STATS_EN adds a saturating beat_count output.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
`ifdef RAM_BURST_CTRL_STATS_EN
  ,
  output logic [15:0]       beat_count
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic              wr_beat;
  logic              rd_issue;
  logic              rd_consume;

  // Beat qualifiers; the write path is zero-latency so RAM strobes follow wr_valid directly.
  assign wr_beat      = (state == WRITE) && wr_valid;
  assign rd_consume   = rd_valid && rd_ready;
  assign rd_issue     = (state == READ) && (!rd_valid || rd_ready);
  assign wr_ready     = (state == WRITE);
  assign busy         = (state != IDLE);
  assign ram_write_en = wr_beat;
  assign ram_addr     = cur_addr;
  assign ram_data_in  = wr_data;

  // Burst sequencing: command latch, address/length stepping, and cmd_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      cmd_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            state     <= cmd_write ? WRITE : READ;
            cmd_ready <= 1'b0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == '0) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_consume) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_burst_rd_stage #(
    .DATA_W (DATA_W)
  ) u_rd_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (rd_issue),
    .clear   (rd_consume),
    .data_in (ram_data_out),
    .last_in (remaining == '0),
    .valid   (rd_valid),
    .data    (rd_data),
    .last    (rd_last)
  );

`ifdef RAM_BURST_CTRL_STATS_EN
  // Saturating count of accepted write beats and consumed read beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= '0;
    end else if ((wr_beat || rd_consume) && (beat_count != 16'hFFFF)) begin
      beat_count <= beat_count + 16'd1;
    end
  end
`endif

endmodule
